// File: rtl/ps2_key_state_tracker_pkg.sv
// Shared PS/2 constants and key index map for the key state tracker.
package ps2_key_state_tracker_pkg;

  // PS/2 scan code set 2 protocol bytes
  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  localparam int KEY_IDX_W = 5;
  localparam int NUMBER_OF_KEYBOARD_INPUTS = 29;

  // Key bitmap indices
  localparam logic [KEY_IDX_W-1:0] KEY_TILDA     = 5'd0;
  localparam logic [KEY_IDX_W-1:0] KEY_1         = 5'd1;
  localparam logic [KEY_IDX_W-1:0] KEY_2         = 5'd2;
  localparam logic [KEY_IDX_W-1:0] KEY_3         = 5'd3;
  localparam logic [KEY_IDX_W-1:0] KEY_4         = 5'd4;
  localparam logic [KEY_IDX_W-1:0] KEY_5         = 5'd5;
  localparam logic [KEY_IDX_W-1:0] KEY_6         = 5'd6;
  localparam logic [KEY_IDX_W-1:0] KEY_7         = 5'd7;
  localparam logic [KEY_IDX_W-1:0] KEY_8         = 5'd8;
  localparam logic [KEY_IDX_W-1:0] KEY_9         = 5'd9;
  localparam logic [KEY_IDX_W-1:0] KEY_0         = 5'd10;
  localparam logic [KEY_IDX_W-1:0] KEY_MINUS     = 5'd11;
  localparam logic [KEY_IDX_W-1:0] KEY_EQUALS    = 5'd12;
  localparam logic [KEY_IDX_W-1:0] KEY_BACKSPACE = 5'd13;
  localparam logic [KEY_IDX_W-1:0] KEY_TAB       = 5'd14;
  localparam logic [KEY_IDX_W-1:0] KEY_Q         = 5'd15;
  localparam logic [KEY_IDX_W-1:0] KEY_W         = 5'd16;
  localparam logic [KEY_IDX_W-1:0] KEY_E         = 5'd17;
  localparam logic [KEY_IDX_W-1:0] KEY_R         = 5'd18;
  localparam logic [KEY_IDX_W-1:0] KEY_T         = 5'd19;
  localparam logic [KEY_IDX_W-1:0] KEY_Y         = 5'd20;
  localparam logic [KEY_IDX_W-1:0] KEY_U         = 5'd21;
  localparam logic [KEY_IDX_W-1:0] KEY_I         = 5'd22;
  localparam logic [KEY_IDX_W-1:0] KEY_O         = 5'd23;
  localparam logic [KEY_IDX_W-1:0] KEY_P         = 5'd24;
  localparam logic [KEY_IDX_W-1:0] KEY_LBRACKET  = 5'd25;
  localparam logic [KEY_IDX_W-1:0] KEY_RBRACKET  = 5'd26;
  localparam logic [KEY_IDX_W-1:0] KEY_BACKSLASH = 5'd27;
  localparam logic [KEY_IDX_W-1:0] KEY_SPACE     = 5'd28;

endpackage

// File: rtl/ps2_key_state_tracker_lut.sv
// Combinational scan code (set 2, non-extended) to key index lookup.
module ps2_scancode_lut
  import ps2_key_state_tracker_pkg::*;
(
  input  logic [7:0]           i_code,
  output logic                 o_hit,
  output logic [KEY_IDX_W-1:0] o_idx
);

  // Decode the tracked scan codes; everything else misses
  always_comb begin
    o_hit = 1'b1;
    o_idx = '0;
    case (i_code)
      8'h0E: o_idx = KEY_TILDA;
      8'h16: o_idx = KEY_1;
      8'h1E: o_idx = KEY_2;
      8'h26: o_idx = KEY_3;
      8'h25: o_idx = KEY_4;
      8'h2E: o_idx = KEY_5;
      8'h36: o_idx = KEY_6;
      8'h3D: o_idx = KEY_7;
      8'h3E: o_idx = KEY_8;
      8'h46: o_idx = KEY_9;
      8'h45: o_idx = KEY_0;
      8'h4E: o_idx = KEY_MINUS;
      8'h55: o_idx = KEY_EQUALS;
      8'h66: o_idx = KEY_BACKSPACE;
      8'h0D: o_idx = KEY_TAB;
      8'h15: o_idx = KEY_Q;
      8'h1D: o_idx = KEY_W;
      8'h24: o_idx = KEY_E;
      8'h2D: o_idx = KEY_R;
      8'h2C: o_idx = KEY_T;
      8'h35: o_idx = KEY_Y;
      8'h3C: o_idx = KEY_U;
      8'h43: o_idx = KEY_I;
      8'h44: o_idx = KEY_O;
      8'h4D: o_idx = KEY_P;
      8'h54: o_idx = KEY_LBRACKET;
      8'h5B: o_idx = KEY_RBRACKET;
      8'h5D: o_idx = KEY_BACKSLASH;
      8'h29: o_idx = KEY_SPACE;
      default: o_hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_key_state_tracker.sv
// Turns the PS/2 received-byte stream into a held-key bitmap and press/release pulses.
module ps2_key_state_tracker
  import ps2_key_state_tracker_pkg::*;
#(
  parameter int NUM_KEYS       = NUMBER_OF_KEYBOARD_INPUTS,
  parameter int PREFIX_TIMEOUT = 2_500_000,
  parameter int TMR_W          = 22
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [NUM_KEYS-1:0]  key_state,
  output logic                 key_event,
  output logic [4:0]           key_event_idx,
  output logic                 key_event_press,
  output logic                 release_pulse,
  output logic                 any_key_down
);

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(PREFIX_TIMEOUT - 1);

  state_t                 r_state, w_state_next;
  logic [TMR_W-1:0]       r_tmr, w_tmr_next;
  logic [NUM_KEYS-1:0]    r_key_state, w_key_state_next;
  logic                   r_evt, w_evt_next;
  logic [KEY_IDX_W-1:0]   r_evt_idx, w_evt_idx_next;
  logic                   r_evt_press, w_evt_press_next;
  logic                   r_rel, w_rel_next;
  logic                   r_any;

  logic                   w_lut_hit;
  logic [KEY_IDX_W-1:0]   w_lut_idx;
  logic                   w_hit;
  logic [NUM_KEYS-1:0]    w_sel;
  logic                   w_held;

  ps2_scancode_lut u_lut (
    .i_code (rx_data),
    .o_hit  (w_lut_hit),
    .o_idx  (w_lut_idx)
  );

  // LUT entries beyond the bitmap width are treated as unmapped keys
  assign w_hit = w_lut_hit && (int'(w_lut_idx) < NUM_KEYS);

  // One-hot select of the addressed key bit
  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_sel
      assign w_sel[gi] = w_hit && (w_lut_idx == KEY_IDX_W'(gi));
    end
  endgenerate

  assign w_held = |(r_key_state & w_sel);

  // Next-state decode: prefix FSM, timeout counter, bitmap and event strobes
  always_comb begin
    w_state_next     = r_state;
    w_tmr_next       = r_tmr;
    w_key_state_next = r_key_state;
    w_evt_next       = 1'b0;
    w_evt_idx_next   = r_evt_idx;
    w_evt_press_next = r_evt_press;
    w_rel_next       = 1'b0;
    if (rx_valid) begin
      // An incoming byte always wins over a coincident timeout
      w_tmr_next = '0;
      case (r_state)
        S_IDLE: begin
          if (rx_data == PS2_BREAK) begin
            w_state_next = S_BRK;
          end else if (rx_data == PS2_EXT) begin
            w_state_next = S_EXT;
          end else if (rx_data == PS2_ERR0 || rx_data == PS2_ERR1) begin
            w_key_state_next = '0;
          end else if (w_hit && !w_held) begin
            w_key_state_next = r_key_state | w_sel;
            w_evt_next       = 1'b1;
            w_evt_idx_next   = w_lut_idx;
            w_evt_press_next = 1'b1;
          end
        end
        S_BRK: begin
          w_state_next = S_IDLE;
          w_rel_next   = 1'b1;
          if (w_held) begin
            w_key_state_next = r_key_state & ~w_sel;
            w_evt_next       = 1'b1;
            w_evt_idx_next   = w_lut_idx;
            w_evt_press_next = 1'b0;
          end
        end
        S_EXT: begin
          w_state_next = (rx_data == PS2_BREAK) ? S_EXT_BRK : S_IDLE;
        end
        default: begin
          // Extended key release: reported as a break, but extended keys are not tracked
          w_state_next = S_IDLE;
          w_rel_next   = 1'b1;
        end
      endcase
    end else if (r_state != S_IDLE) begin
      if (r_tmr == TMO_LAST) begin
        w_state_next = S_IDLE;
        w_tmr_next   = '0;
      end else if (r_tmr != '1) begin
        w_tmr_next = r_tmr + 1'b1;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_tmr       <= '0;
      r_key_state <= '0;
      r_evt       <= 1'b0;
      r_evt_idx   <= '0;
      r_evt_press <= 1'b0;
      r_rel       <= 1'b0;
      r_any       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_tmr       <= w_tmr_next;
      r_key_state <= w_key_state_next;
      r_evt       <= w_evt_next;
      r_evt_idx   <= w_evt_idx_next;
      r_evt_press <= w_evt_press_next;
      r_rel       <= w_rel_next;
      r_any       <= |w_key_state_next;
    end
  end

  assign key_state       = r_key_state;
  assign key_event       = r_evt;
  assign key_event_idx   = r_evt_idx;
  assign key_event_press = r_evt_press;
  assign release_pulse   = r_rel;
  assign any_key_down    = r_any;

endmodule

// File: tb/tb_ps2_key_state_tracker.sv
// Scoreboard bench for ps2_key_state_tracker with a short prefix timeout.
module tb_ps2_key_state_tracker;

  localparam int NK  = 29;
  localparam int PTO = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [NK-1:0] key_state;
  logic          key_event;
  logic [4:0]    key_event_idx;
  logic          key_event_press;
  logic          release_pulse;
  logic          any_key_down;

  ps2_key_state_tracker #(.NUM_KEYS(NK), .PREFIX_TIMEOUT(PTO), .TMR_W(4)) dut (
    .CLOCK_50        (clk),
    .resetn          (resetn),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .key_state       (key_state),
    .key_event       (key_event),
    .key_event_idx   (key_event_idx),
    .key_event_press (key_event_press),
    .release_pulse   (release_pulse),
    .any_key_down    (any_key_down)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic       ev;
    logic [4:0] idx;
    logic       press;
    logic       rel;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [4:0] hold_idx = '0;
  logic       hold_press = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endfunction

  function automatic void push_ev(logic [4:0] idx, logic press, logic rel);
    exp_t e;
    e.ev = 1'b1; e.idx = idx; e.press = press; e.rel = rel;
    hold_idx = idx; hold_press = press;
    exp_q.push_back(e);
  endfunction

  function automatic void push_rel();
    exp_t e;
    e.ev = 1'b0; e.idx = hold_idx; e.press = hold_press; e.rel = 1'b1;
    exp_q.push_back(e);
  endfunction

  task automatic send(logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_state(string name, logic [NK-1:0] exp_ks);
    check({name, "_key_state"}, 32'(key_state), 32'(exp_ks));
    check({name, "_any_down"}, 32'(any_key_down), 32'(|exp_ks));
  endtask

  // Monitor: pop and compare whenever the DUT reports an event or release
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (key_event || release_pulse) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: ev=%0b idx=%0d press=%0b rel=%0b expected none",
                   key_event, key_event_idx, key_event_press, release_pulse);
        end else begin
          e = exp_q.pop_front();
          $display("txn  ev=%0b idx=%0d press=%0b rel=%0b", key_event, key_event_idx,
                   key_event_press, release_pulse);
          check("sb_event", 32'(key_event), 32'(e.ev));
          check("sb_idx",   32'(key_event_idx), 32'(e.idx));
          check("sb_press", 32'(key_event_press), 32'(e.press));
          check("sb_rel",   32'(release_pulse), 32'(e.rel));
        end
      end
    end
  end

  initial begin
    resetn   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_key_state", 32'(key_state), 32'd0);
    check("rst_outputs", {27'd0, key_event, release_pulse, any_key_down, key_event_press, 1'b0},
          32'd0);
    check("rst_idx", 32'(key_event_idx), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Press Q, then its release
    push_ev(5'd15, 1'b1, 1'b0);
    send(8'h15);
    check_state("t1_press", NK'(1) << 15);
    idle(1);
    check("t1_event_cleared", 32'(key_event), 32'd0);
    check("t1_idx_hold", 32'(key_event_idx), 32'd15);
    push_ev(5'd15, 1'b0, 1'b1);
    send(8'hF0);
    send(8'h15);
    check_state("t3_release", '0);

    // Typematic repeat: one event only
    push_ev(5'd15, 1'b1, 1'b0);
    send(8'h15); send(8'h15); send(8'h15);
    check_state("t2_repeat", NK'(1) << 15);
    push_ev(5'd15, 1'b0, 1'b1);
    send(8'hF0); send(8'h15);

    // Extended press/release are not tracked; one release pulse for E0 F0 75
    send(8'hE0); send(8'h75);
    push_rel();
    send(8'hE0); send(8'hF0); send(8'h75);
    check_state("t4_ext", '0);
    push_ev(5'd16, 1'b1, 1'b0);
    send(8'h1D);
    check_state("t4_w", NK'(1) << 16);

    // Break prefix expires before the next byte: treated as a press
    send(8'hF0);
    idle(PTO);
    push_ev(5'd17, 1'b1, 1'b0);
    send(8'h24);
    check_state("t5_timeout", (NK'(1) << 16) | (NK'(1) << 17));
    // Byte arrives before the timeout
    send(8'hF0);
    idle(PTO - 2);
    push_ev(5'd16, 1'b0, 1'b1);
    send(8'h1D);
    // Byte on the same cycle as the timeout still completes the break
    send(8'hF0);
    idle(PTO - 1);
    push_ev(5'd17, 1'b0, 1'b1);
    send(8'h24);
    check_state("t5_released", '0);

    // Release of a key not held, ignored/unmapped bytes, E0-consumed byte
    push_rel();
    send(8'hF0); send(8'h66);
    send(8'h76); send(8'hAA); send(8'hFA); send(8'hFE);
    send(8'hE0); send(8'h15);
    check_state("ignored", '0);

    // Overrun codes clear the bitmap silently
    push_ev(5'd15, 1'b1, 1'b0);
    send(8'h15);
    send(8'h00);
    check_state("err00", '0);
    push_ev(5'd28, 1'b1, 1'b0);
    push_ev(5'd0,  1'b1, 1'b0);
    push_ev(5'd27, 1'b1, 1'b0);
    push_ev(5'd13, 1'b1, 1'b0);
    push_ev(5'd10, 1'b1, 1'b0);
    send(8'h29); send(8'h0E); send(8'h5D); send(8'h66); send(8'h45);
    check_state("map_edges", (NK'(1) << 28) | NK'(1) | (NK'(1) << 27) | (NK'(1) << 13)
                | (NK'(1) << 10));
    send(8'hFF);
    check_state("errFF", '0);

    // Async reset mid-sequence discards the pending break
    push_ev(5'd28, 1'b1, 1'b0);
    push_ev(5'd1,  1'b1, 1'b0);
    send(8'h29); send(8'h16);
    send(8'hF0);
    resetn = 1'b0;
    hold_idx = '0; hold_press = 1'b0;
    #2;
    check_state("t6_reset", '0);
    check("t6_rst_idx", 32'(key_event_idx), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    push_ev(5'd15, 1'b1, 1'b0);
    send(8'h15);
    check_state("t6_after", NK'(1) << 15);

    idle(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
